// File: rtl/warp_dispatcher_pkg.sv
// Shared types for the warp dispatcher: FSM encoding and instruction width.
// The {inst, mask} entry struct is declared in warp_dispatcher, where NUM_LANES is known.
package warp_pkg;

    localparam int INST_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        WAIT  = 2'd3
    } dispatch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers and a combinational head view.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    // Same low bits with opposite wrap bits means the writer lapped the reader.
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign count = wptr - rptr;
    assign head  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/warp_dispatcher.sv
// Issue stage: queues masked warp instructions and broadcasts them one at a time,
// waiting for every enabled lane to return ready, with a sticky timeout on hung lanes.
module warp_dispatcher
    import warp_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INST_W-1:0]          in_inst,
    input  logic [NUM_LANES-1:0]       in_mask,
    output logic                       lane_execute,
    output logic [NUM_LANES-1:0]       lane_enable,
    output logic [INST_W-1:0]          lane_instruction,
    input  logic [NUM_LANES-1:0]       lane_ready,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [15:0]                issued_count,
    output logic                       timeout_err
);

    typedef struct packed {
        logic [INST_W-1:0]    inst;
        logic [NUM_LANES-1:0] mask;
    } dispatch_entry_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    dispatch_state_e      state, state_nxt;
    dispatch_entry_t      in_entry, head;
    logic                 full, empty;
    logic                 pop, latch, complete, tmo_hit;
    logic                 head_ok, wait_done;
    logic [NUM_LANES-1:0] cur_mask;
    logic [INST_W-1:0]    cur_inst;
    logic [TW-1:0]        tmo_cnt;

    assign in_entry = {in_inst, in_mask};

    sync_fifo #(
        .WIDTH ($bits(dispatch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (pop),
        .wdata (in_entry),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign head_ok   = !empty && (head.mask != '0) && ((lane_ready & head.mask) == head.mask);
    assign wait_done = ((lane_ready & cur_mask) == cur_mask);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        latch     = 1'b0;
        complete  = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                // Zero-mask entries are dropped here without ever reaching the lanes.
                if (!empty && head.mask == '0) begin
                    pop = 1'b1;
                end else if (head_ok) begin
                    pop       = 1'b1;
                    latch     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = GAP;
            GAP:   state_nxt = WAIT;
            WAIT: begin
                if (wait_done) begin
                    complete = 1'b1;
                    if (head_ok) begin
                        pop       = 1'b1;
                        latch     = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cur_inst     <= '0;
            cur_mask     <= '0;
            tmo_cnt      <= '0;
            issued_count <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (latch) begin
                cur_inst <= head.inst;
                cur_mask <= head.mask;
            end
            if (state == GAP)       tmo_cnt <= '0;
            else if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
            if (complete) issued_count <= issued_count + 16'd1;
            if (tmo_hit)  timeout_err  <= 1'b1;
        end
    end

    assign in_ready         = !full;
    assign lane_execute     = (state == ISSUE);
    assign lane_enable      = (state == IDLE) ? '0 : cur_mask;
    assign lane_instruction = cur_inst;
    assign busy             = !empty || (state != IDLE);

endmodule

// File: tb/tb_warp_dispatcher.sv
// Directed bench for warp_dispatcher with a simple lane model that drops ready after execute.
module tb_warp_dispatcher;

    localparam int NL = 8;
    localparam int DP = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_inst = '0;
    logic [NL-1:0] in_mask = '0;
    logic          lane_execute;
    logic [NL-1:0] lane_enable;
    logic [31:0]   lane_instruction;
    logic [NL-1:0] lane_ready;
    logic          busy;
    logic [2:0]    fifo_count;
    logic [15:0]   issued_count;
    logic          timeout_err;

    int total = 0;
    int bad   = 0;

    // Lane model: after sampling execute, all lanes stay not-ready for lat cycles;
    // hold_low forces individual lanes low independently.
    int            lat = 0;
    int            busy_left = 0;
    logic [NL-1:0] hold_low = '0;
    int            cyc = 0;

    logic [31:0]   ilog[$];
    logic [NL-1:0] elog[$];
    int            clog[$];

    warp_dispatcher #(.NUM_LANES(NL), .DEPTH(DP), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_inst          (in_inst),
        .in_mask          (in_mask),
        .lane_execute     (lane_execute),
        .lane_enable      (lane_enable),
        .lane_instruction (lane_instruction),
        .lane_ready       (lane_ready),
        .busy             (busy),
        .fifo_count       (fifo_count),
        .issued_count     (issued_count),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    assign lane_ready = (busy_left > 0) ? '0 : ~hold_low;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lane_execute && lat > 0) busy_left <= lat;
        else if (busy_left > 0)      busy_left <= busy_left - 1;
    end

    always @(negedge clk) begin
        if (lane_execute) begin
            ilog.push_back(lane_instruction);
            elog.push_back(lane_enable);
            clog.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ilog.delete();
        elog.delete();
        clog.delete();
    endtask

    task automatic push(input logic [31:0] i, input logic [NL-1:0] m);
        int t = 0;
        in_valid = 1'b1;
        in_inst  = i;
        in_mask  = m;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("push_wait", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int t = 0;
        while (busy && t < lim) begin
            @(negedge clk);
            t++;
        end
        chk("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_exec(input int lim);
        int t = 0;
        while (!lane_execute && t < lim) begin
            @(negedge clk);
            t++;
        end
        chk("exec_wait", {31'd0, lane_execute}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;

        // Reset values
        do_reset();
        chk("rst_exec",   lane_execute, 0);
        chk("rst_enable", lane_enable, 0);
        chk("rst_inst",   lane_instruction, 0);
        chk("rst_inrdy",  in_ready, 1);
        chk("rst_busy",   busy, 0);
        chk("rst_cnt",    fifo_count, 0);
        chk("rst_issued", issued_count, 0);
        chk("rst_err",    timeout_err, 0);

        // Single issue: strobe one cycle, two cycles after the push edge
        do_reset();
        lat = 4;
        push(32'h1234_5678, 8'hFF);
        chk("s_cnt",   fifo_count, 1);
        chk("s_exec0", lane_execute, 0);
        @(negedge clk);
        chk("s_exec1", lane_execute, 1);
        chk("s_inst",  lane_instruction, 32'h1234_5678);
        chk("s_en",    lane_enable, 8'hFF);
        @(negedge clk);
        chk("s_exec2", lane_execute, 0);
        chk("s_engap", lane_enable, 8'hFF);
        wait_idle(100);
        chk("s_issued", issued_count, 1);
        chk("s_pulses", ilog.size(), 1);
        chk("s_hold",   lane_instruction, 32'h1234_5678);
        chk("s_enidle", lane_enable, 0);

        // Fill and back-pressure with lanes held not-ready
        do_reset();
        lat = 2;
        hold_low = 8'hFF;
        for (int i = 0; i < 4; i++) push(32'hA000_0000 + i, 8'hFF);
        chk("f_rdy",   in_ready, 0);
        chk("f_cnt",   fifo_count, 4);
        chk("f_noexe", ilog.size(), 0);
        fork
            push(32'hA000_0004, 8'hFF);
            begin
                repeat (3) @(negedge clk);
                hold_low = '0;
            end
        join
        wait_idle(300);
        chk("f_n", ilog.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < ilog.size()) chk("f_order", ilog[i], 32'hA000_0000 + i);
        chk("f_issued", issued_count, 5);

        // Zero mask entry is discarded without a strobe
        do_reset();
        lat = 2;
        push(32'hDEAD_0000, 8'h00);
        chk("z_cnt1", fifo_count, 1);
        push(32'hBEEF_0001, 8'h0F);
        chk("z_cnt2", fifo_count, 1);
        wait_idle(100);
        chk("z_n", ilog.size(), 1);
        if (ilog.size() > 0) begin
            chk("z_inst", ilog[0], 32'hBEEF_0001);
            chk("z_en",   elog[0], 8'h0F);
        end
        chk("z_issued", issued_count, 1);

        // Partial mask stall: lane 1 never returns, instruction times out
        do_reset();
        lat = 0;
        hold_low = '0;
        push(32'hC000_0000, 8'h03);
        wait_exec(20);
        hold_low = 8'h02;
        t = 0;
        push(32'hC000_0001, 8'h0C);
        t = 1;
        while (!timeout_err && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("t_lat",    t, 18);
        chk("t_err",    timeout_err, 1);
        chk("t_issued", issued_count, 0);
        chk("t_enidle", lane_enable, 0);
        wait_idle(100);
        chk("t_n", ilog.size(), 2);
        if (ilog.size() > 1) chk("t_next", ilog[1], 32'hC000_0001);
        chk("t_issued2", issued_count, 1);
        chk("t_sticky",  timeout_err, 1);
        hold_low = '0;

        // Back-to-back with lanes always ready: 3-cycle issue interval
        do_reset();
        lat = 0;
        chk("b_errclr", timeout_err, 0);
        for (int i = 0; i < 4; i++) push(32'hB000_0000 + i, 8'hFF);
        wait_idle(100);
        chk("b_n", ilog.size(), 4);
        for (int i = 1; i < 4; i++)
            if (i < clog.size()) chk("b_gap", clog[i] - clog[i-1], 3);
        for (int i = 0; i < 4; i++)
            if (i < ilog.size()) chk("b_order", ilog[i], 32'hB000_0000 + i);
        chk("b_issued", issued_count, 4);
        chk("b_err",    timeout_err, 0);

        // Reset asserted mid-WAIT drops in-flight and queued work
        do_reset();
        lat = 10;
        push(32'hD000_0000, 8'hFF);
        push(32'hD000_0001, 8'hFF);
        wait_exec(20);
        repeat (3) @(negedge clk);
        chk("m_enpre",  lane_enable, 8'hFF);
        chk("m_busypre", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("m_en",     lane_enable, 0);
        chk("m_cnt",    fifo_count, 0);
        chk("m_busy",   busy, 0);
        chk("m_issued", issued_count, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("m_drop", ilog.size(), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
